// File: rtl/game_pkg.sv
// Shared game types and screen geometry for the per-frame pong blocks.
package game_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SERVE  = 3'd1,
        PLAY   = 3'd2,
        SCORED = 3'd3,
        OVER   = 3'd4
    } gameState_e;

    localparam int VIDEO_WIDTH   = 640;
    localparam int VIDEO_HEIGHT  = 480;
    localparam int SQUARE_DIM    = 50;
    localparam int BALL_HOME_X   = 270;
    localparam int LEFT_GOAL_X   = 160;
    localparam int RIGHT_GOAL_X  = 430;
    localparam int SPRITE_DIGITS = 36;

endpackage

// File: rtl/pong_game_controller_if.sv
// Frame timing / processor inputs and compositor-facing outputs of the game sequencer.
interface pong_game_controller_if;

    logic       screenEnd;
    logic       startGame;
    logic       player;
    logic [7:0] moveSpeed;
    logic [9:0] ballX;
    logic [7:0] leftScore;
    logic [7:0] rightScore;
    logic       showStartScreen;
    logic       gameOver;
    logic       pointPulse;

    modport master (
        output screenEnd, startGame, player, moveSpeed,
        input  ballX, leftScore, rightScore, showStartScreen, gameOver, pointPulse
    );

    modport slave (
        input  screenEnd, startGame, player, moveSpeed,
        output ballX, leftScore, rightScore, showStartScreen, gameOver, pointPulse
    );

endinterface

// File: rtl/frame_tick_detect.sv
// Rising-edge detector on the frame-boundary level: one clk of tick per pulse.
// Combinational tick in the first cycle screenEnd is seen high; history cleared on reset.
module frame_tick_detect (
    input  logic clk,
    input  logic reset,
    input  logic screenEnd,
    output logic tick
);

    logic screenEndQ;

    always_ff @(posedge clk) begin
        if (reset) begin
            screenEndQ <= 1'b0;
        end else begin
            screenEndQ <= screenEnd;
        end
    end

    assign tick = screenEnd & ~screenEndQ;

endmodule

// File: rtl/pong_game_controller.sv
// Frame-rate pong sequencer: ball X, scores and idle/serve/play/score/over flow.
// Acts on the clk edge of each frame tick; all outputs registered, visible next cycle.
module pong_game_controller #(
    parameter int BALL_HOME_X  = game_pkg::BALL_HOME_X,
    parameter int LEFT_GOAL_X  = game_pkg::LEFT_GOAL_X,
    parameter int RIGHT_GOAL_X = game_pkg::RIGHT_GOAL_X,
    parameter int SPEED_SHIFT  = 5,
    parameter int SERVE_FRAMES = 60,
    parameter int WIN_SCORE    = 11
) (
    input  logic                   clk,
    input  logic                   reset,
    pong_game_controller_if.slave  gameIf
);

    import game_pkg::*;

    localparam logic [2:0] S_IDLE   = IDLE;
    localparam logic [2:0] S_SERVE  = SERVE;
    localparam logic [2:0] S_PLAY   = PLAY;
    localparam logic [2:0] S_SCORED = SCORED;
    localparam logic [2:0] S_OVER   = OVER;

    localparam int                 CNT_W      = $clog2(SERVE_FRAMES + 1);
    localparam logic [9:0]         HOME_X     = 10'(BALL_HOME_X);
    localparam logic signed [10:0] LEFT_LIM   = 11'(LEFT_GOAL_X);
    localparam logic signed [10:0] RIGHT_LIM  = 11'(RIGHT_GOAL_X);
    localparam logic [7:0]         WIN        = 8'(WIN_SCORE);
    localparam logic [CNT_W-1:0]   SERVE_LAST = CNT_W'(SERVE_FRAMES - 1);

    logic tick;

    frame_tick_detect uTick (
        .clk       (clk),
        .reset     (reset),
        .screenEnd (gameIf.screenEnd),
        .tick      (tick)
    );

    logic [2:0]       state, nextState;
    logic [CNT_W-1:0] serveCnt, serveCntNext;
    logic [9:0]       ballXReg, ballXNext;
    logic [7:0]       leftReg, leftNext;
    logic [7:0]       rightReg, rightNext;
    logic             pointReg, pointNext;
    logic             showReg, overReg;
    logic             frameGo;
    logic [7:0]       delta;
    logic signed [10:0] ballStep;

    assign frameGo = tick & gameIf.startGame;
    assign delta   = gameIf.moveSpeed >> SPEED_SHIFT;

    // 11-bit signed so a step past zero reads as negative, i.e. beyond the left goal.
    assign ballStep = gameIf.player ? ($signed({1'b0, ballXReg}) - $signed({3'b000, delta}))
                                    : ($signed({1'b0, ballXReg}) + $signed({3'b000, delta}));

    always_comb begin
        nextState    = state;
        serveCntNext = serveCnt;
        ballXNext    = ballXReg;
        leftNext     = leftReg;
        rightNext    = rightReg;
        pointNext    = 1'b0;
        case (state)
            S_IDLE: begin
                ballXNext = HOME_X;
                if (frameGo) begin
                    leftNext     = '0;
                    rightNext    = '0;
                    serveCntNext = '0;
                    nextState    = S_SERVE;
                end
            end
            S_SERVE: begin
                ballXNext = HOME_X;
                if (frameGo) begin
                    serveCntNext = serveCnt + CNT_W'(1);
                    if (serveCnt == SERVE_LAST) begin
                        nextState = S_PLAY;
                    end
                end
            end
            S_PLAY: begin
                if (frameGo && (delta != 8'd0)) begin
                    if (ballStep < LEFT_LIM) begin
                        if (rightReg < WIN) rightNext = rightReg + 8'd1;
                        ballXNext = HOME_X;
                        pointNext = 1'b1;
                        nextState = S_SCORED;
                    end else if (ballStep > RIGHT_LIM) begin
                        if (leftReg < WIN) leftNext = leftReg + 8'd1;
                        ballXNext = HOME_X;
                        pointNext = 1'b1;
                        nextState = S_SCORED;
                    end else begin
                        ballXNext = ballStep[9:0];
                    end
                end
            end
            S_SCORED: begin
                ballXNext = HOME_X;
                if ((leftReg == WIN) || (rightReg == WIN)) begin
                    nextState = S_OVER;
                end else begin
                    serveCntNext = '0;
                    nextState    = S_SERVE;
                end
            end
            S_OVER: begin
                ballXNext = HOME_X;
                if (tick && !gameIf.startGame) begin
                    nextState = S_IDLE;
                end
            end
            default: begin
                ballXNext = HOME_X;
                nextState = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            serveCnt <= '0;
            ballXReg <= HOME_X;
            leftReg  <= '0;
            rightReg <= '0;
            pointReg <= 1'b0;
            showReg  <= 1'b1;
            overReg  <= 1'b0;
        end else begin
            state    <= nextState;
            serveCnt <= serveCntNext;
            ballXReg <= ballXNext;
            leftReg  <= leftNext;
            rightReg <= rightNext;
            pointReg <= pointNext;
            showReg  <= (nextState == S_IDLE);
            overReg  <= (nextState == S_OVER);
        end
    end

    assign gameIf.ballX           = ballXReg;
    assign gameIf.leftScore       = leftReg;
    assign gameIf.rightScore      = rightReg;
    assign gameIf.pointPulse      = pointReg;
    assign gameIf.showStartScreen = showReg;
    assign gameIf.gameOver        = overReg;

endmodule

// File: tb/tb_pong_game_controller.sv
// Bench for pong_game_controller: directed scenarios plus a random frame stream against a tick-level model.
module tb_pong_game_controller;

    localparam int HOME = 270;
    localparam int LG   = 160;
    localparam int RG   = 430;
    localparam int SFR  = 60;
    localparam int WIN  = 3;

    logic clk = 1'b0;
    logic reset = 1'b1;

    pong_game_controller_if pongIf();

    pong_game_controller #(.WIN_SCORE(WIN)) dut (
        .clk    (clk),
        .reset  (reset),
        .gameIf (pongIf)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    int   pulseCount = 0;
    int   pulseWide  = 0;
    logic prevPulse  = 1'b0;

    always @(negedge clk) begin
        if (pongIf.pointPulse === 1'b1) begin
            pulseCount++;
            if (prevPulse === 1'b1) pulseWide++;
        end
        prevPulse = pongIf.pointPulse;
    end

    // Reference model: one call per frame, the one-clk scoring state collapsed into the point.
    typedef enum {M_IDLE, M_SERVE, M_PLAY, M_OVER} mState_e;
    mState_e mState;
    int mBall, mLeft, mRight, mCnt;
    int mPoints = 0;

    function automatic void modelReset();
        mState = M_IDLE; mBall = HOME; mLeft = 0; mRight = 0; mCnt = 0;
    endfunction

    function automatic void modelTick(bit st, bit pl, int speed);
        int d, nx;
        d = speed / 32;
        case (mState)
            M_IDLE: if (st) begin mLeft = 0; mRight = 0; mCnt = 0; mState = M_SERVE; end
            M_SERVE: if (st) begin mCnt++; if (mCnt == SFR) mState = M_PLAY; end
            M_PLAY: if (st && d != 0) begin
                nx = pl ? mBall - d : mBall + d;
                if (nx < LG || nx > RG) begin
                    if (nx < LG) mRight = (mRight < WIN) ? mRight + 1 : WIN;
                    else         mLeft  = (mLeft  < WIN) ? mLeft  + 1 : WIN;
                    mBall = HOME;
                    mPoints++;
                    if (mLeft == WIN || mRight == WIN) mState = M_OVER;
                    else begin mCnt = 0; mState = M_SERVE; end
                end else begin
                    mBall = nx;
                end
            end
            M_OVER: if (!st) mState = M_IDLE;
            default: mState = M_IDLE;
        endcase
    endfunction

    task automatic doReset();
        @(negedge clk);
        reset = 1'b1;
        pongIf.screenEnd = 1'b0; pongIf.startGame = 1'b0;
        pongIf.player = 1'b0; pongIf.moveSpeed = 8'd0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        modelReset();
    endtask

    task automatic frame(int hi, int lo, bit st, bit pl, int spd);
        pongIf.startGame = st; pongIf.player = pl; pongIf.moveSpeed = 8'(spd);
        pongIf.screenEnd = 1'b1;
        repeat (hi) @(negedge clk);
        pongIf.screenEnd = 1'b0;
        repeat (lo) @(negedge clk);
        modelTick(st, pl, spd);
    endtask

    task automatic toPlay();
        doReset();
        frame(1, 1, 1'b1, 1'b0, 0);
        repeat (SFR) frame(1, 1, 1'b1, 1'b0, 0);
    endtask

    task automatic test_reset();
        doReset();
        repeat (10) @(negedge clk);
        checks++; if (pongIf.ballX !== 10'd270) begin errors++; $display("FAIL reset_ballX got %0d want 270", pongIf.ballX); end
        checks++; if (pongIf.leftScore !== 8'd0 || pongIf.rightScore !== 8'd0) begin errors++; $display("FAIL reset_scores got %0d/%0d want 0/0", pongIf.leftScore, pongIf.rightScore); end
        checks++; if (pongIf.showStartScreen !== 1'b1) begin errors++; $display("FAIL reset_show got %b want 1", pongIf.showStartScreen); end
        checks++; if (pongIf.gameOver !== 1'b0) begin errors++; $display("FAIL reset_over got %b want 0", pongIf.gameOver); end
        checks++; if (pulseCount !== 0) begin errors++; $display("FAIL reset_pulse got %0d want 0", pulseCount); end
    endtask

    task automatic test_serve();
        doReset();
        frame(1, 2, 1'b1, 1'b0, 255);
        checks++; if (pongIf.showStartScreen !== 1'b0) begin errors++; $display("FAIL serve_enter show got %b want 0", pongIf.showStartScreen); end
        for (int i = 2; i <= 61; i++) begin
            if (i == 31) begin
                frame(2, 1, 1'b0, 1'b0, 255);
                frame(1, 1, 1'b0, 1'b0, 255);
            end
            frame(1 + (i % 3), 1, 1'b1, 1'b0, 255);
            checks++; if (pongIf.ballX !== 10'd270) begin errors++; $display("FAIL serve_hold tick %0d ballX got %0d want 270", i, pongIf.ballX); end
        end
        frame(1, 1, 1'b1, 1'b0, 255);
        checks++; if (pongIf.ballX !== 10'd277) begin errors++; $display("FAIL serve_play_entry ballX got %0d want 277", pongIf.ballX); end
    endtask

    task automatic test_held_pulse();
        toPlay();
        repeat (5) frame(4, 2, 1'b1, 1'b0, 64);
        checks++; if (pongIf.ballX !== 10'd280) begin errors++; $display("FAIL held_pulse ballX got %0d want 280", pongIf.ballX); end
    endtask

    task automatic test_right_point();
        int p0;
        toPlay();
        p0 = pulseCount;
        repeat (15) frame(1, 1, 1'b1, 1'b1, 255);
        checks++; if (pongIf.ballX !== 10'd165 || pongIf.rightScore !== 8'd0) begin errors++; $display("FAIL right_pre ballX/right got %0d/%0d want 165/0", pongIf.ballX, pongIf.rightScore); end
        frame(1, 1, 1'b1, 1'b1, 255);
        checks++; if (pongIf.rightScore !== 8'd1 || pongIf.ballX !== 10'd270) begin errors++; $display("FAIL right_point right/ballX got %0d/%0d want 1/270", pongIf.rightScore, pongIf.ballX); end
        checks++; if (pulseCount - p0 !== 1 || pulseWide !== 0) begin errors++; $display("FAIL right_pulse count/wide got %0d/%0d want 1/0", pulseCount - p0, pulseWide); end
        frame(1, 1, 1'b1, 1'b1, 255);
        checks++; if (pongIf.ballX !== 10'd270 || pongIf.gameOver !== 1'b0 || pongIf.showStartScreen !== 1'b0) begin errors++; $display("FAIL right_serve ballX/over/show got %0d/%b/%b want 270/0/0", pongIf.ballX, pongIf.gameOver, pongIf.showStartScreen); end
    endtask

    task automatic test_goal_edge();
        toPlay();
        repeat (55) frame(1, 1, 1'b1, 1'b1, 64);
        checks++; if (pongIf.ballX !== 10'd160 || pongIf.rightScore !== 8'd0) begin errors++; $display("FAIL edge_left_eq ballX/right got %0d/%0d want 160/0", pongIf.ballX, pongIf.rightScore); end
        frame(1, 1, 1'b1, 1'b1, 64);
        checks++; if (pongIf.rightScore !== 8'd1) begin errors++; $display("FAIL edge_left_past right got %0d want 1", pongIf.rightScore); end
        repeat (SFR) frame(1, 1, 1'b1, 1'b0, 64);
        repeat (80) frame(1, 1, 1'b1, 1'b0, 64);
        checks++; if (pongIf.ballX !== 10'd430 || pongIf.leftScore !== 8'd0) begin errors++; $display("FAIL edge_right_eq ballX/left got %0d/%0d want 430/0", pongIf.ballX, pongIf.leftScore); end
        frame(1, 1, 1'b1, 1'b0, 31);
        checks++; if (pongIf.ballX !== 10'd430) begin errors++; $display("FAIL edge_zero_delta ballX got %0d want 430", pongIf.ballX); end
        frame(1, 1, 1'b1, 1'b0, 64);
        checks++; if (pongIf.leftScore !== 8'd1 || pongIf.ballX !== 10'd270) begin errors++; $display("FAIL edge_right_past left/ballX got %0d/%0d want 1/270", pongIf.leftScore, pongIf.ballX); end
    endtask

    task automatic test_win();
        toPlay();
        for (int p = 0; p < WIN; p++) begin
            if (p > 0) repeat (SFR) frame(1, 1, 1'b1, 1'b0, 255);
            repeat (23) frame(1, 1, 1'b1, 1'b0, 255);
            checks++; if (pongIf.leftScore !== 8'(p + 1)) begin errors++; $display("FAIL win_point%0d left got %0d want %0d", p, pongIf.leftScore, p + 1); end
        end
        checks++; if (pongIf.gameOver !== 1'b1 || pongIf.rightScore !== 8'd0) begin errors++; $display("FAIL win_over over/right got %b/%0d want 1/0", pongIf.gameOver, pongIf.rightScore); end
        frame(1, 1, 1'b1, 1'b0, 255);
        checks++; if (pongIf.gameOver !== 1'b1 || pongIf.leftScore !== 8'd3 || pongIf.ballX !== 10'd270) begin errors++; $display("FAIL win_hold over/left/ballX got %b/%0d/%0d want 1/3/270", pongIf.gameOver, pongIf.leftScore, pongIf.ballX); end
        frame(1, 1, 1'b0, 1'b0, 255);
        checks++; if (pongIf.showStartScreen !== 1'b1 || pongIf.gameOver !== 1'b0 || pongIf.leftScore !== 8'd3) begin errors++; $display("FAIL win_idle show/over/left got %b/%b/%0d want 1/0/3", pongIf.showStartScreen, pongIf.gameOver, pongIf.leftScore); end
        frame(1, 1, 1'b1, 1'b0, 255);
        checks++; if (pongIf.leftScore !== 8'd0 || pongIf.rightScore !== 8'd0 || pongIf.showStartScreen !== 1'b0) begin errors++; $display("FAIL win_restart scores/show got %0d/%0d/%b want 0/0/0", pongIf.leftScore, pongIf.rightScore, pongIf.showStartScreen); end
    endtask

    task automatic test_reset_mid_play();
        int p0;
        toPlay();
        repeat (2) begin
            repeat (23) frame(1, 1, 1'b1, 1'b0, 255);
            repeat (SFR) frame(1, 1, 1'b1, 1'b0, 255);
        end
        repeat (15) frame(1, 1, 1'b1, 1'b0, 64);
        checks++; if (pongIf.ballX !== 10'd300 || pongIf.leftScore !== 8'd2) begin errors++; $display("FAIL midreset_pre ballX/left got %0d/%0d want 300/2", pongIf.ballX, pongIf.leftScore); end
        p0 = pulseCount;
        reset = 1'b1; pongIf.startGame = 1'b1; pongIf.moveSpeed = 8'd255;
        @(negedge clk);
        reset = 1'b0;
        modelReset();
        checks++; if (pongIf.ballX !== 10'd270 || pongIf.leftScore !== 8'd0 || pongIf.rightScore !== 8'd0) begin errors++; $display("FAIL midreset ballX/scores got %0d/%0d/%0d want 270/0/0", pongIf.ballX, pongIf.leftScore, pongIf.rightScore); end
        checks++; if (pongIf.showStartScreen !== 1'b1 || pulseCount !== p0) begin errors++; $display("FAIL midreset_state show/pulses got %b/%0d want 1/%0d", pongIf.showStartScreen, pulseCount, p0); end
    endtask

    task automatic test_random();
        bit pl = 1'b0;
        bit st;
        doReset();
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 199) == 0) doReset();
            if ($urandom_range(0, 7) == 0) pl = ~pl;
            st = ($urandom_range(0, 9) != 0);
            frame($urandom_range(1, 4), $urandom_range(1, 3), st, pl, $urandom_range(0, 255));
            checks++;
            if (pongIf.ballX !== 10'(mBall) || pongIf.leftScore !== 8'(mLeft) || pongIf.rightScore !== 8'(mRight)) begin
                errors++;
                $display("FAIL random_pos frame %0d ballX/left/right got %0d/%0d/%0d want %0d/%0d/%0d",
                         n, pongIf.ballX, pongIf.leftScore, pongIf.rightScore, mBall, mLeft, mRight);
            end
            checks++;
            if (pongIf.showStartScreen !== (mState == M_IDLE) || pongIf.gameOver !== (mState == M_OVER) || pulseCount !== mPoints) begin
                errors++;
                $display("FAIL random_flags frame %0d show/over/pulses got %b/%b/%0d want %b/%b/%0d",
                         n, pongIf.showStartScreen, pongIf.gameOver, pulseCount,
                         (mState == M_IDLE), (mState == M_OVER), mPoints);
            end
        end
        checks++; if (pulseWide !== 0) begin errors++; $display("FAIL random_pulse_width wide pulses got %0d want 0", pulseWide); end
    endtask

    initial begin
        pongIf.screenEnd = 1'b0;
        pongIf.startGame = 1'b0;
        pongIf.player    = 1'b0;
        pongIf.moveSpeed = 8'd0;
        modelReset();
        test_reset();
        test_serve();
        test_held_pulse();
        test_right_point();
        test_goal_edge();
        test_win();
        test_reset_mid_play();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
